// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and width helpers
// Also intended for the coefficient multiply and adder blocks.
package fir_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_TAPS  = 8;

   // Width of a counter that must represent 0..taps inclusive.
   function automatic int cnt_width(input int taps);
      return $clog2(taps + 1);
   endfunction

   function automatic int idx_width(input int taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/fir_delay_line_if.sv
// rtl/fir_delay_line_if.sv - sample-in / window-out handshake bundle
// master drives samples and consumes windows; slave is the delay line.
interface fir_delay_line_if #(
   parameter int WIDTH = fir_pkg::DEFAULT_WIDTH,
   parameter int TAPS  = fir_pkg::DEFAULT_TAPS
);
   import fir_pkg::*;

   localparam int CW = cnt_width(TAPS);

   logic                  clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [TAPS*WIDTH-1:0] taps_flat;
   logic [CW-1:0]         fill_cnt;
   logic                  primed;

   modport master (
      output clear, in_valid, in_data, out_ready,
      input  in_ready, out_valid, taps_flat, fill_cnt, primed
   );

   modport slave (
      input  clear, in_valid, in_data, out_ready,
      output in_ready, out_valid, taps_flat, fill_cnt, primed
   );

endinterface

// File: rtl/fir_tap_reg.sv
// rtl/fir_tap_reg.sv - one delay-line tap: async-reset register with load enable
module fir_tap_reg
   import fir_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - FIR sample delay line with fill tracking and window handshake
// Tap 0 holds the newest sample; a window is presented once per qualifying accept.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int TAPS       = DEFAULT_TAPS,
   parameter int PRIME_MODE = 0
) (
   input logic             clk,
   input logic             rst,
   fir_delay_line_if.slave bus
);

   localparam int CW = cnt_width(TAPS);
   localparam logic [CW-1:0] FULL = CW'(TAPS);

   logic             accept;
   logic             tap_load;
   logic [WIDTH-1:0] tap_q [TAPS];
   logic [WIDTH-1:0] tap_d [TAPS];

   logic [CW-1:0]    fill_cnt_q, fill_cnt_d, fill_inc;
   logic             out_valid_q, out_valid_d;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.clear;
   // clear reuses the load path to zero every tap in the same edge.
   assign tap_load     = accept || bus.clear;

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      if (k == 0) begin : g_head
         assign tap_d[k] = bus.clear ? '0 : bus.in_data;
      end else begin : g_body
         assign tap_d[k] = bus.clear ? '0 : tap_q[k-1];
      end

      fir_tap_reg #(.WIDTH(WIDTH)) u_tap (
         .clk    (clk),
         .rst    (rst),
         .load_i (tap_load),
         .d_i    (tap_d[k]),
         .q_o    (tap_q[k])
      );

      assign bus.taps_flat[k*WIDTH +: WIDTH] = tap_q[k];
   end

   always_comb begin
      fill_inc    = (fill_cnt_q == FULL) ? fill_cnt_q : fill_cnt_q + CW'(1);
      fill_cnt_d  = fill_cnt_q;
      out_valid_d = out_valid_q;
      if (bus.clear) begin
         fill_cnt_d  = '0;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         // A qualifying accept wins over the consume, so the new window follows directly.
         if (accept) begin
            fill_cnt_d = fill_inc;
            if (PRIME_MODE != 0 || fill_inc == FULL) begin
               out_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fill_cnt_q  <= fill_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.fill_cnt  = fill_cnt_q;
   assign bus.primed    = (fill_cnt_q == FULL);

endmodule

// File: doc/fir_delay_line.md
FIR_DELAY_LINE -- requirements
Module: fir_delay_line

Interface
REQ-001 Parameter WIDTH, 8, sample width in bits (>=1).
REQ-002 Parameter TAPS, 8, number of delay taps (>=2).
REQ-003 Parameter PRIME_MODE, 0, 0 = output windows only once line is full; 1 = output windows from first sample with zero-filled taps.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clear  input  1  synchronous flush of taps and fill state.
REQ-007 in_valid  input  1  in_data holds a sample.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 in_data  input  WIDTH  input sample.
REQ-010 out_valid  output  1  taps_flat holds an unconsumed window.
REQ-011 out_ready  input  1  downstream consumes window this cycle.
REQ-012 taps_flat  output  TAPS*WIDTH  tap k at bits [k*WIDTH +: WIDTH]; tap 0 newest, tap TAPS-1 oldest.
REQ-013 fill_cnt  output  clog2(TAPS+1)  samples held, saturating at TAPS.
REQ-014 primed  output  1  high when fill_cnt == TAPS.

Function
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinational, no dependence on in_valid.
REQ-016 accept = in_valid && in_ready && !clear; on accept, tap 0 <= in_data and tap k <= tap k-1 for k = 1..TAPS-1; otherwise taps hold.
REQ-017 On accept, fill_cnt SHALL increment by 1, saturating at TAPS; no wrap-around.
REQ-018 PRIME_MODE 0: out_valid SHALL be set the cycle after an accept whose resulting fill_cnt == TAPS.
REQ-019 PRIME_MODE 1: out_valid SHALL be set the cycle after every accept.
REQ-020 Latency: in_data accepted at edge N appears in tap 0 and (if qualifying) out_valid = 1 after edge N.
REQ-021 out_valid SHALL clear after an edge where out_valid && out_ready and no qualifying accept occurs; accept plus consume in the same cycle keeps out_valid = 1 with the new window.
REQ-022 While out_valid && !out_ready, taps_flat and out_valid SHALL hold stable; in_ready = 0 (backpressure).
REQ-023 clear SHALL zero all taps, fill_cnt and out_valid at the next edge, taking priority over a simultaneous accept (that sample is dropped).
REQ-024 Tap arithmetic: none; data moves bit-exact, no sign extension or truncation.

Reset
REQ-025 rst high SHALL immediately force all taps to 0, fill_cnt = 0, out_valid = 0, primed = 0; in_ready = 1 consequently.
REQ-026 rst asserted mid-stream SHALL discard all held samples and any pending window; first sample after release behaves as from a fresh line.

Structure
REQ-027 Shared package fir_pkg SHALL hold default WIDTH/TAPS constants and the tap-index/fill-count width function, shared with the future coefficient multiply and adder blocks.
REQ-028 Each tap SHALL be an instance of sub-module fir_tap_reg (WIDTH-parametrised, async-reset register with load enable), generated TAPS times.
REQ-029 Control (fill_cnt, out_valid) SHALL live in fir_delay_line itself, not in fir_tap_reg.

Verification (WIDTH=8, TAPS=4)
REQ-030 Mode 0, out_ready=1, feed 0x11,0x22,0x33,0x44 back-to-back -> out_valid first high after 4th accept with taps_flat = 0x11223344 (tap 3 = 0x11, tap 0 = 0x44); primed = 1.
REQ-031 Mode 1, feed 0xA5 after reset -> out_valid next cycle, taps_flat = 0x000000A5, fill_cnt = 1.
REQ-032 Primed line, out_ready=0 for 3 cycles with in_valid=1 -> in_ready = 0, taps_flat and out_valid frozen; out_ready=1 -> pending sample accepted, window shifts one.
REQ-033 Feed 10 samples -> fill_cnt saturates at 4, never wraps to 0; taps hold last 4 samples.
REQ-034 clear asserted with in_valid=1 in same cycle -> next cycle taps_flat = 0, fill_cnt = 0, out_valid = 0, sample dropped.
REQ-035 rst pulsed asynchronously between edges on a primed line -> outputs zero immediately, before next clock edge; refill needs 4 new samples in mode 0.
